// File: rtl/prescaled_mode_counter_if.sv
// Control and status bundle for prescaled_mode_counter.
// The master modport drives controls; the slave modport is the counter side.
interface prescaled_mode_counter_if #(
    parameter int OUT_WIDTH = 4
);
    logic                 en_in;
    logic                 dir_in;
    logic [1:0]           mode_in;
    logic                 load_in;
    logic [OUT_WIDTH-1:0] load_val_in;
    logic [OUT_WIDTH-1:0] out;
    logic                 tick_out;
    logic                 tc_out;
    logic                 dir_out;

    modport master (
        output en_in, dir_in, mode_in, load_in, load_val_in,
        input  out, tick_out, tc_out, dir_out
    );

    modport slave (
        input  en_in, dir_in, mode_in, load_in, load_val_in,
        output out, tick_out, tc_out, dir_out
    );
endinterface

// File: rtl/prescaled_mode_counter.sv
// Prescaled step counter with wrap / saturate / bounce modes, load, and strobes.
// state  | meaning
// B_UP   | bounce mode is currently stepping toward MAX
// B_DOWN | bounce mode is currently stepping toward MIN
module prescaled_mode_counter #(
    parameter int TIMING_SCALE = 24,
    parameter int OUT_WIDTH    = 4,
    parameter int MIN          = 0,
    parameter int MAX          = 2**OUT_WIDTH-1,
    parameter int STEP         = 1
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    prescaled_mode_counter_if.slave bus
);
    localparam int PW = $clog2(TIMING_SCALE) + 1;
    localparam int W  = OUT_WIDTH + 1;

    localparam logic [PW-1:0]        PRESC_LAST = PW'(TIMING_SCALE - 1);
    localparam logic [OUT_WIDTH-1:0] MIN_O      = OUT_WIDTH'(MIN);
    localparam logic [OUT_WIDTH-1:0] MAX_O      = OUT_WIDTH'(MAX);
    localparam logic [OUT_WIDTH-1:0] STEP_O     = OUT_WIDTH'(STEP);
    localparam logic [W-1:0]         MIN_X      = W'(MIN);
    localparam logic [W-1:0]         MAX_X      = W'(MAX);
    localparam logic [W-1:0]         STEP_X     = W'(STEP);

    typedef enum logic {B_UP = 1'b0, B_DOWN = 1'b1} bounce_t;

    bounce_t              b_state, b_next, b_eff;
    logic [PW-1:0]        presc;
    logic [OUT_WIDTH-1:0] cnt, step_val, dn_o, load_clamped;
    logic [W-1:0]         cnt_x, up_x;
    logic                 tick_int, step_tc, advance;
    logic                 under_lt, under_le, tick_r, tc_r, dir_r;

    assign tick_int = bus.en_in && (presc == PRESC_LAST);
    assign advance  = tick_int && !bus.load_in;

    always_ff @(posedge clk_in) begin
        if (rst_in)
            b_state <= B_UP;
        else if (advance)
            b_state <= b_next;
    end

    // Step arithmetic carries one extra bit so up/down bound checks cannot alias.
    always_comb begin
        cnt_x    = {1'b0, cnt};
        up_x     = cnt_x + STEP_X;
        dn_o     = cnt - STEP_O;
        under_lt = cnt_x <  (MIN_X + STEP_X);
        under_le = cnt_x <= (MIN_X + STEP_X);
        step_val = cnt;
        step_tc  = 1'b0;
        b_next   = b_state;
        case (bus.mode_in)
            2'b01: begin
                if (!bus.dir_in) begin
                    if (up_x >= MAX_X) begin
                        step_val = MAX_O;
                        step_tc  = (cnt != MAX_O);
                    end else begin
                        step_val = up_x[OUT_WIDTH-1:0];
                    end
                end else begin
                    if (under_le) begin
                        step_val = MIN_O;
                        step_tc  = (cnt != MIN_O);
                    end else begin
                        step_val = dn_o;
                    end
                end
            end
            2'b10: begin
                if (b_state == B_UP) begin
                    if (up_x >= MAX_X) begin
                        step_val = MAX_O;
                        step_tc  = 1'b1;
                        b_next   = B_DOWN;
                    end else begin
                        step_val = up_x[OUT_WIDTH-1:0];
                    end
                end else begin
                    if (under_le) begin
                        step_val = MIN_O;
                        step_tc  = 1'b1;
                        b_next   = B_UP;
                    end else begin
                        step_val = dn_o;
                    end
                end
            end
            default: begin
                if (!bus.dir_in) begin
                    if (up_x > MAX_X) begin
                        step_val = MIN_O;
                        step_tc  = 1'b1;
                    end else begin
                        step_val = up_x[OUT_WIDTH-1:0];
                    end
                end else begin
                    if (under_lt) begin
                        step_val = MAX_O;
                        step_tc  = 1'b1;
                    end else begin
                        step_val = dn_o;
                    end
                end
            end
        endcase

        b_eff = advance ? b_next : b_state;

        if (bus.load_val_in < MIN_O)
            load_clamped = MIN_O;
        else if (bus.load_val_in > MAX_O)
            load_clamped = MAX_O;
        else
            load_clamped = bus.load_val_in;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            presc  <= '0;
            cnt    <= MIN_O;
            tick_r <= 1'b0;
            tc_r   <= 1'b0;
            dir_r  <= 1'b0;
        end else begin
            dir_r <= (bus.mode_in == 2'b10) ? (b_eff == B_DOWN) : bus.dir_in;
            if (bus.load_in) begin
                presc  <= '0;
                cnt    <= load_clamped;
                tick_r <= 1'b0;
                tc_r   <= 1'b0;
            end else if (tick_int) begin
                presc  <= '0;
                cnt    <= step_val;
                tick_r <= 1'b1;
                tc_r   <= step_tc;
            end else begin
                if (bus.en_in)
                    presc <= presc + PW'(1);
                tick_r <= 1'b0;
                tc_r   <= 1'b0;
            end
        end
    end

    assign bus.out      = cnt;
    assign bus.tick_out = tick_r;
    assign bus.tc_out   = tc_r;
    assign bus.dir_out  = dir_r;
endmodule

// File: tb/tb_prescaled_mode_counter.sv
// Randomised and directed bench for prescaled_mode_counter against an integer reference model.
module tb_prescaled_mode_counter;
    localparam int TS = 3;
    localparam int OW = 4;
    localparam int MN = 2;
    localparam int MX = 9;
    localparam int ST = 3;

    logic clk_in = 1'b0;
    logic rst_in;
    int   n_tests = 0;
    int   n_fail  = 0;

    int m_presc, m_val;
    bit m_bdir, e_tick, e_tc, e_dir;

    always #5 clk_in = ~clk_in;

    prescaled_mode_counter_if #(.OUT_WIDTH(OW)) bus();

    prescaled_mode_counter #(
        .TIMING_SCALE(TS), .OUT_WIDTH(OW), .MIN(MN), .MAX(MX), .STEP(ST)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input int mode, input bit dir);
        int nv;
        e_tc = 0;
        nv   = m_val;
        case (mode)
            1: begin
                if (!dir) nv = (m_val + ST > MX) ? MX : m_val + ST;
                else      nv = (m_val - ST < MN) ? MN : m_val - ST;
                e_tc = (m_val != nv) && (nv == (dir ? MN : MX));
            end
            2: begin
                if (!m_bdir) begin
                    if (m_val + ST >= MX) begin nv = MX; m_bdir = 1; e_tc = 1; end
                    else nv = m_val + ST;
                end else begin
                    if (m_val - ST <= MN) begin nv = MN; m_bdir = 0; e_tc = 1; end
                    else nv = m_val - ST;
                end
            end
            default: begin
                if (!dir) begin
                    if (m_val + ST > MX) begin nv = MN; e_tc = 1; end
                    else nv = m_val + ST;
                end else begin
                    if (m_val - ST < MN) begin nv = MX; e_tc = 1; end
                    else nv = m_val - ST;
                end
            end
        endcase
        m_val = nv;
    endtask

    task automatic cycle();
        int lv;
        @(posedge clk_in);
        if (rst_in) begin
            m_presc = 0; m_val = MN; m_bdir = 0;
            e_tick = 0; e_tc = 0; e_dir = 0;
        end else begin
            e_tick = 0; e_tc = 0;
            if (bus.load_in) begin
                lv      = int'(bus.load_val_in);
                m_val   = (lv < MN) ? MN : (lv > MX) ? MX : lv;
                m_presc = 0;
            end else if (bus.en_in && m_presc == TS - 1) begin
                m_presc = 0;
                e_tick  = 1;
                model_step(int'(bus.mode_in), bus.dir_in);
            end else if (bus.en_in) begin
                m_presc++;
            end
            e_dir = (bus.mode_in == 2'b10) ? m_bdir : bus.dir_in;
        end
        #1;
        chk("out",  32'(bus.out),      32'(m_val));
        chk("tick", 32'(bus.tick_out), 32'(e_tick));
        chk("tc",   32'(bus.tc_out),   32'(e_tc));
        chk("dir",  32'(bus.dir_out),  32'(e_dir));
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        cycle();
        rst_in = 1'b0;
    endtask

    initial begin
        rst_in          = 1'b1;
        bus.en_in       = 1'b1;
        bus.dir_in      = 1'b0;
        bus.mode_in     = 2'b00;
        bus.load_in     = 1'b0;
        bus.load_val_in = '0;
        cycle();
        cycle();
        chk("rst_out",  32'(bus.out),      32'd2);
        chk("rst_tick", 32'(bus.tick_out), 32'd0);
        chk("rst_tc",   32'(bus.tc_out),   32'd0);
        chk("rst_dir",  32'(bus.dir_out),  32'd0);
        rst_in = 1'b0;

        repeat (15) cycle();
        bus.dir_in = 1'b1;
        repeat (15) cycle();

        do_reset();
        bus.mode_in = 2'b01; bus.dir_in = 1'b0;
        repeat (20) cycle();
        bus.dir_in = 1'b1;
        repeat (20) cycle();

        do_reset();
        bus.mode_in = 2'b10;
        repeat (30) cycle();

        // load on a tick edge: clamp to MAX, tick discarded, prescaler restarts
        for (int i = 0; i < TS && m_presc != TS - 1; i++) cycle();
        bus.load_in = 1'b1; bus.load_val_in = 4'd15;
        cycle();
        chk("load_hi_out",  32'(bus.out),      32'd9);
        chk("load_hi_tick", 32'(bus.tick_out), 32'd0);
        bus.load_in = 1'b0;
        cycle();
        cycle();
        chk("load_no_early_tick", 32'(bus.tick_out), 32'd0);
        cycle();
        chk("load_step_tick", 32'(bus.tick_out), 32'd1);
        bus.load_in = 1'b1; bus.load_val_in = 4'd0;
        cycle();
        chk("load_lo_out", 32'(bus.out), 32'd2);
        bus.load_in = 1'b0;

        // enable hold mid-period
        bus.mode_in = 2'b00; bus.dir_in = 1'b0;
        do_reset();
        cycle();
        cycle();
        bus.en_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("hold_out",  32'(bus.out),      32'd2);
            chk("hold_tick", 32'(bus.tick_out), 32'd0);
        end
        bus.en_in = 1'b1;
        cycle();
        chk("resume_tick", 32'(bus.tick_out), 32'd1);
        chk("resume_out",  32'(bus.out),      32'd5);

        // reset mid-period discards partial period
        cycle();
        do_reset();
        chk("midrst_out",  32'(bus.out),      32'd2);
        chk("midrst_tick", 32'(bus.tick_out), 32'd0);
        chk("midrst_tc",   32'(bus.tc_out),   32'd0);
        cycle();
        cycle();
        chk("midrst_no_tick", 32'(bus.tick_out), 32'd0);
        cycle();
        chk("midrst_tick3", 32'(bus.tick_out), 32'd1);

        for (int i = 0; i < 3000; i++) begin
            rst_in          = ($urandom_range(0, 149) == 0);
            bus.load_in     = ($urandom_range(0, 15) == 0);
            bus.en_in       = ($urandom_range(0, 9) != 0);
            bus.load_val_in = OW'($urandom_range(0, 15));
            if ($urandom_range(0, 31) == 0) bus.mode_in = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) bus.dir_in  = 1'($urandom_range(0, 1));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
